// File: rtl/pendulum_calib_seq.sv
// Pendulum calibration sequencer: seek the end-stop, debounce it, settle under servo lock, then pulse zero_pos.
// Optional macro CALIB_AUTOSTART_EN: start one calibration automatically after every reset release.
module pendulum_calib_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES   = 2500000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic clear_fault,
  input  logic calib_done,
  output logic calib_start,
  output logic trava_servo,
  output logic zero_pos,
  output logic busy,
  output logic calibrated,
  output logic fault
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_DEB, S_SETTLE, S_DONE, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic             cd_meta_q, cd_s_q;
  logic             calib_start_q, calib_start_d;
  logic             trava_servo_q, trava_servo_d;
  logic             zero_pos_q, zero_pos_d;
  logic             busy_q, busy_d;
  logic             calibrated_q, calibrated_d;
  logic             fault_q, fault_d;
  logic             start_eff;
  logic             tmo_hit;

`ifdef CALIB_AUTOSTART_EN
  // Set by reset, cleared on the first running edge: one implicit start per reset.
  logic auto_q, auto_d;
  assign auto_d = 1'b0;
  always_ff @(posedge clk) begin
    if (!rst_n) auto_q <= 1'b1;
    else        auto_q <= auto_d;
  end
  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // State register, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmo_cnt_q     <= '0;
      deb_cnt_q     <= '0;
      set_cnt_q     <= '0;
      cd_meta_q     <= 1'b0;
      cd_s_q        <= 1'b0;
      calib_start_q <= 1'b0;
      trava_servo_q <= 1'b0;
      zero_pos_q    <= 1'b0;
      busy_q        <= 1'b0;
      calibrated_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      deb_cnt_q     <= deb_cnt_d;
      set_cnt_q     <= set_cnt_d;
      cd_meta_q     <= calib_done;
      cd_s_q        <= cd_meta_q;
      calib_start_q <= calib_start_d;
      trava_servo_q <= trava_servo_d;
      zero_pos_q    <= zero_pos_d;
      busy_q        <= busy_d;
      calibrated_q  <= calibrated_d;
      fault_q       <= fault_d;
    end
  end

  // Next state and counters; abort wins, timeout beats debounce completion.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    deb_cnt_d = deb_cnt_q;
    set_cnt_d = set_cnt_q;
    if (abort) begin
      state_d   = S_IDLE;
      tmo_cnt_d = '0;
      deb_cnt_d = '0;
      set_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_eff) begin
            tmo_cnt_d = '0;
            deb_cnt_d = '0;
            state_d   = cd_s_q ? S_DEB : S_SEEK;
          end
        end
        S_SEEK: begin
          tmo_cnt_d = tmo_cnt_q + CNT_ONE;
          if (tmo_hit) begin
            state_d = S_FAULT;
          end else if (cd_s_q) begin
            state_d   = S_DEB;
            deb_cnt_d = '0;
          end
        end
        S_DEB: begin
          tmo_cnt_d = tmo_cnt_q + CNT_ONE;
          if (tmo_hit) begin
            state_d = S_FAULT;
          end else if (!cd_s_q) begin
            state_d   = S_SEEK;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d   = S_SETTLE;
            set_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
          end
        end
        S_SETTLE: begin
          set_cnt_d = set_cnt_q + CNT_ONE;
          if (set_cnt_q == SET_LAST) state_d = S_DONE;
        end
        S_FAULT: begin
          if (clear_fault) begin
            state_d   = S_IDLE;
            tmo_cnt_d = '0;
            deb_cnt_d = '0;
            set_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state; zero_pos marks the SETTLE->DONE edge.
  always_comb begin
    calib_start_d = 1'b0;
    trava_servo_d = 1'b0;
    busy_d        = 1'b0;
    calibrated_d  = 1'b0;
    fault_d       = 1'b0;
    zero_pos_d    = (state_q == S_SETTLE) && (state_d == S_DONE);
    unique case (state_d)
      S_SEEK, S_DEB: begin
        calib_start_d = 1'b1;
        busy_d        = 1'b1;
      end
      S_SETTLE: begin
        trava_servo_d = 1'b1;
        busy_d        = 1'b1;
      end
      S_DONE:  calibrated_d = 1'b1;
      S_FAULT: begin
        trava_servo_d = 1'b1;
        fault_d       = 1'b1;
      end
      default: ;
    endcase
  end

  assign calib_start = calib_start_q;
  assign trava_servo = trava_servo_q;
  assign zero_pos    = zero_pos_q;
  assign busy        = busy_q;
  assign calibrated  = calibrated_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pendulum_calib_seq.sv
// Directed bench for pendulum_calib_seq with DEBOUNCE=4, SETTLE=8, TIMEOUT=100.
module tb_pendulum_calib_seq;

  logic clk = 1'b0;
  logic rst_n, start, abort, clear_fault, calib_done;
  logic calib_start, trava_servo, zero_pos, busy, calibrated, fault;

  int checks = 0;
  int errors = 0;

  // Output vector order: {calib_start, trava_servo, zero_pos, busy, calibrated, fault}
  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_SEEK   = 6'b100100;
  localparam logic [5:0] O_SETTLE = 6'b010100;
  localparam logic [5:0] O_ZERO   = 6'b001010;
  localparam logic [5:0] O_DONE   = 6'b000010;
  localparam logic [5:0] O_FAULT  = 6'b010001;

  pendulum_calib_seq #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .clear_fault(clear_fault),
    .calib_done (calib_done),
    .calib_start(calib_start),
    .trava_servo(trava_servo),
    .zero_pos   (zero_pos),
    .busy       (busy),
    .calibrated (calibrated),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {calib_start, trava_servo, zero_pos, busy, calibrated, fault};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start pulse before edge 1; calib_done driven before the numbered edges.
  task automatic run(input string name, input int g_on, input int g_off, input int rise,
                     input int settle_at, input int end_at);
    logic [5:0] exp;
    int zc;
    zc = 0;
    start = 1'b1;
    step();
    chk($sformatf("%s cyc1", name), O_SEEK);
    start = 1'b0;
    for (int i = 2; i <= end_at; i++) begin
      if (i == g_on)  calib_done = 1'b1;
      if (i == g_off) calib_done = 1'b0;
      if (i == rise)  calib_done = 1'b1;
      step();
      zc += int'(zero_pos);
      if (i < settle_at)          exp = O_SEEK;
      else if (i < settle_at + 8) exp = O_SETTLE;
      else if (i == settle_at + 8) exp = O_ZERO;
      else                        exp = O_DONE;
      chk($sformatf("%s cyc%0d", name, i), exp);
    end
    chk_int($sformatf("%s zero_pos_count", name), zc, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; clear_fault = 1'b0; calib_done = 1'b0;
    repeat (3) step();
    chk("reset", O_IDLE);
    rst_n = 1'b1;
    step();
`ifdef CALIB_AUTOSTART_EN
    chk("post_reset", O_SEEK);
    abort = 1'b1; step(); abort = 1'b0;
    chk("autostart_abort", O_IDLE);
`else
    chk("post_reset", O_IDLE);
`endif

    // 1: nominal, end-stop from cycle 20
    run("nominal", -1, -1, 20, 26, 35);

    // 2: glitch at 20-21, real hit from 40
    calib_done = 1'b0;
    repeat (3) step();
    chk("done_hold", O_DONE);
    run("glitch", 20, 22, 40, 46, 55);

    // 3: timeout, calib_done stays low
    calib_done = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    chk("tmo cyc1", O_SEEK);
    start = 1'b0;
    repeat (98) step();
    chk("tmo cyc99", O_SEEK);
    step();
    chk("tmo cyc100", O_SEEK);
    step();
    chk("tmo cyc101", O_FAULT);
    start = 1'b1;
    repeat (2) step();
    chk("fault_ignores_start", O_FAULT);
    start = 1'b0;
    clear_fault = 1'b1;
    step();
    chk("clear_fault", O_IDLE);
    clear_fault = 1'b0;

    // 6 + 4: pre-pressed end-stop bypasses SEEK; abort at set_cnt=7
    calib_done = 1'b1;
    repeat (3) step();
    chk("prepress_idle", O_IDLE);
    start = 1'b1;
    step();
    chk("prepress cyc1", O_SEEK);
    start = 1'b0;
    repeat (3) step();
    chk("prepress cyc4", O_SEEK);
    step();
    chk("prepress cyc5_settle", O_SETTLE);
    repeat (7) step();
    chk("settle set_cnt7", O_SETTLE);
    abort = 1'b1;
    step();
    chk("abort_in_zero_cycle", O_IDLE);
    step();
    chk("abort_stays_idle", O_IDLE);
    start = 1'b1;
    step();
    chk("start_and_abort", O_IDLE);
    abort = 1'b0;
    start = 1'b0;

    // 5: reset during DEBOUNCE
    start = 1'b1;
    step();
    chk("rst_run cyc1", O_SEEK);
    start = 1'b0;
    step();
    chk("rst_run cyc2", O_SEEK);
    rst_n = 1'b0;
    step();
    chk("mid_reset", O_IDLE);
    chk_int("sync_meta_cleared", int'(dut.cd_meta_q), 0);
    chk_int("sync_s_cleared", int'(dut.cd_s_q), 0);
    calib_done = 1'b0;
    rst_n = 1'b1;
    step();
`ifdef CALIB_AUTOSTART_EN
    chk("release", O_SEEK);
`else
    chk("release", O_IDLE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pendulum_calib_seq.md
Name: pendulum_calib_seq

Overview:
Calibration sequencer on the initiator side of the pendulum calibration handshake. It raises calib_start toward the pendulum input mux and consumes calib_done, which is the end-stop sensor level. It debounces the end-stop hit, then holds the servo locked through trava_servo while the mechanism settles. It then pulses zero_pos so the position counter takes the home reference, and reports calibrated or fault status to the game FSM.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive synced-high cycles of calib_done required to accept the end-stop (1 ms @ 50 MHz)
SETTLE_CYCLES, 2500000, cycles trava_servo is held after the accepted hit, before zero_pos (50 ms)
TIMEOUT_CYCLES, 500000000, maximum cycles allowed in SEEK+DEBOUNCE before FAULT (10 s)
CNT_W, 32, width of all internal counters; must hold the largest of the above

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  request calibration; level-sampled, acted on in IDLE/DONE only
abort  in  1  cancel calibration from any state
clear_fault  in  1  leave FAULT
calib_done  in  1  end-stop level from the mux (asynchronous to clk)
calib_start  out  1  drive request toward the mux
trava_servo  out  1  servo lock request toward the mux
zero_pos  out  1  one-cycle pulse: latch home position
busy  out  1  high in SEEK, DEBOUNCE, SETTLE
calibrated  out  1  high in DONE
fault  out  1  high in FAULT

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low. While rst_n=0 on a rising edge: state=IDLE, all counters=0, sync FFs=0, all outputs=0.
- calib_done passes through a 2-FF synchronizer; the FSM uses only the synced value cd_s. This adds 2 cycles of latency from pin to FSM.
- All outputs are registered and decoded from the next state. When a transition is taken at edge N, the outputs for the new state are valid after edge N.
- States and outputs:
  - IDLE: all outputs 0.
  - SEEK: calib_start=1, busy=1.
  - DEBOUNCE: calib_start=1, busy=1.
  - SETTLE: trava_servo=1, busy=1.
  - DONE: calibrated=1.
  - FAULT: trava_servo=1, fault=1.
- IDLE or DONE, start=1: go to SEEK, clear tmo_cnt, clear deb_cnt. If cd_s is already 1, go to DEBOUNCE instead.
- SEEK: tmo_cnt increments each cycle.
  - cd_s=1: go to DEBOUNCE with deb_cnt=0.
  - tmo_cnt==TIMEOUT_CYCLES-1: go to FAULT.
- DEBOUNCE: tmo_cnt keeps incrementing; deb_cnt increments while cd_s=1.
  - cd_s=0: go to SEEK, deb_cnt=0; tmo_cnt is not cleared.
  - deb_cnt==DEBOUNCE_CYCLES-1 with cd_s=1: go to SETTLE, set_cnt=0.
  - Timeout check as in SEEK; timeout has priority over the debounce-complete condition in the same cycle.
- SETTLE: set_cnt increments each cycle; cd_s is ignored.
  - set_cnt==SETTLE_CYCLES-1: zero_pos=1 for exactly that one cycle, then go to DONE.
- DONE: holds until start or abort.
- FAULT: holds until clear_fault=1, then go to IDLE. start is ignored in FAULT.
- abort=1 in any state: go to IDLE next cycle and zero all counters. If abort is asserted in the zero_pos cycle, zero_pos is suppressed.
- Priority per cycle: rst_n > abort > clear_fault > timeout > other transitions.
- start held high continuously does not retrigger a calibration that is in progress. In DONE it starts a new run; calibrated drops on the transition.
- Counter compares use equality against PARAM-1. Each parameter must be ≥1; with value 1 the corresponding state lasts one cycle.

Optional Feature:
CALIB_AUTOSTART_EN
- Defined: the first cycle after rst_n deasserts behaves as if start=1 in IDLE, so calibration begins without a request. This happens once per reset.
- Undefined: the block waits in IDLE for start.

Test Plan:
Parameters for all scenarios: DEBOUNCE=4, SETTLE=8, TIMEOUT=100.
1. Nominal run: start pulse, calib_done rises at cycle 20 and stays high.
   -> calib_start high from cycle 1 to 25.
   -> trava_servo high for 8 cycles.
   -> zero_pos one cycle, then calibrated=1.
2. Glitch: calib_done high for 2 cycles at cycle 20, low, then high from cycle 40.
   -> Returns to SEEK after the glitch.
   -> SETTLE is entered only after cycle 40 plus sync and debounce.
   -> Exactly one zero_pos.
3. Timeout: start, calib_done held 0.
   -> fault=1 at cycle 101, with trava_servo=1 and calib_start=0.
   -> clear_fault returns to IDLE with all outputs 0.
4. Abort: abort during SETTLE at set_cnt=7.
   -> No zero_pos; IDLE next cycle with calibrated=0.
   -> Also check start and abort asserted together in IDLE: stays in IDLE.
5. Reset mid-run: rst_n=0 for 1 cycle during DEBOUNCE.
   -> All outputs 0 on the next edge.
   -> Sync FFs cleared.
   -> With CALIB_AUTOSTART_EN defined, calib_start=1 one cycle after release.
6. Pre-pressed end-stop: calib_done=1 before start.
   -> SEEK is bypassed to DEBOUNCE.
   -> SETTLE is entered 4 cycles later.
